// File: rtl/shift_reg_univ.sv
// shift_reg_univ: parametrised universal shift register with a frame counter.
// Shift-class edges count up to WIDTH and pulse frame_done; load/clear restart the frame.
module shift_reg_univ #(
    parameter int              WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int              CNT_W       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             sout,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             frame_done
);
    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_SHR  = 3'b001,
        M_SHL  = 3'b010,
        M_ROR  = 3'b011,
        M_ROL  = 3'b100,
        M_LOAD = 3'b101,
        M_ASR  = 3'b110,
        M_CLR  = 3'b111
    } mode_t;
    mode_t            op;
    logic [WIDTH-1:0] q_nxt;
    logic             is_shift;
    logic             restart;
    logic             wrap;
    assign op       = mode_t'(mode);
    assign is_shift = (op == M_SHR) || (op == M_SHL) || (op == M_ROR) || (op == M_ROL) || (op == M_ASR);
    assign restart  = (op == M_LOAD) || (op == M_CLR);
    assign wrap     = bit_cnt == CNT_W'(WIDTH - 1);
    assign sout     = (op == M_SHL || op == M_ROL) ? Q[WIDTH-1] : Q[0];
    always_comb begin
        q_nxt = Q;
        case (op)
            M_SHR:   q_nxt = {sin, Q[WIDTH-1:1]};
            M_SHL:   q_nxt = {Q[WIDTH-2:0], sin};
            M_ROR:   q_nxt = {Q[0], Q[WIDTH-1:1]};
            M_ROL:   q_nxt = {Q[WIDTH-2:0], Q[WIDTH-1]};
            M_LOAD:  q_nxt = D;
            M_ASR:   q_nxt = {Q[WIDTH-1], Q[WIDTH-1:1]};
            M_CLR:   q_nxt = '0;
            default: q_nxt = Q;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Q          <= RESET_VALUE;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= en && is_shift && wrap;
            if (en) begin
                Q <= q_nxt;
                if (restart)
                    bit_cnt <= '0;
                else if (is_shift)
                    bit_cnt <= wrap ? '0 : bit_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_shift_reg_univ.sv
// tb_shift_reg_univ: directed checks of shift_reg_univ at WIDTH=4, RESET_VALUE=0.
module tb_shift_reg_univ;
    logic       clk;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic       sin;
    logic [3:0] D;
    logic [3:0] Q;
    logic       sout;
    logic [1:0] bit_cnt;
    logic       frame_done;
    int checks = 0;
    int errors = 0;

    shift_reg_univ #(.WIDTH(4), .RESET_VALUE(4'b0000)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sin(sin), .D(D),
        .Q(Q), .sout(sout), .bit_cnt(bit_cnt), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b0; mode = 3'b000; sin = 1'b0; D = 4'b0000;
        #12;
        checks++;
        if (Q !== 4'b0000 || bit_cnt !== 2'd0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_init Q=%b cnt=%0d fd=%b want 0000 0 0", Q, bit_cnt, frame_done);
        end
        reset = 1'b1;
        en = 1'b1; mode = 3'b101; D = 4'b1111;
        tick();
        mode = 3'b011;
        tick();
        tick();
        checks++;
        if (Q !== 4'b1111 || bit_cnt !== 2'd2) begin
            errors++;
            $display("FAIL reset_pre Q=%b cnt=%0d want 1111 2", Q, bit_cnt);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if (Q !== 4'b0000 || bit_cnt !== 2'd0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async Q=%b cnt=%0d fd=%b want 0000 0 0", Q, bit_cnt, frame_done);
        end
        mode = 3'b000;
        #2 reset = 1'b1;
    endtask

    task automatic test_s2p();
        logic [3:0] eq [4];
        logic [1:0] ec [4];
        logic       si [4];
        eq = '{4'b1000, 4'b0100, 4'b0010, 4'b1001};
        ec = '{2'd1, 2'd2, 2'd3, 2'd0};
        si = '{1'b1, 1'b0, 1'b0, 1'b1};
        en = 1'b1; mode = 3'b111;
        tick();
        mode = 3'b001;
        for (int i = 0; i < 4; i++) begin
            sin = si[i];
            tick();
            checks++;
            if (Q !== eq[i] || bit_cnt !== ec[i] || frame_done !== (i == 3)) begin
                errors++;
                $display("FAIL s2p_%0d Q=%b cnt=%0d fd=%b want %b %0d %b", i, Q, bit_cnt, frame_done, eq[i], ec[i], i == 3);
            end
        end
        mode = 3'b000;
        tick();
        checks++;
        if (frame_done !== 1'b0 || Q !== 4'b1001) begin
            errors++;
            $display("FAIL s2p_after fd=%b Q=%b want 0 1001", frame_done, Q);
        end
    endtask

    task automatic test_p2s();
        logic       es [4];
        logic [3:0] eq [4];
        es = '{1'b1, 1'b0, 1'b1, 1'b0};
        eq = '{4'b0100, 4'b1000, 4'b0000, 4'b0000};
        en = 1'b1; mode = 3'b101; D = 4'b1010;
        tick();
        checks++;
        if (Q !== 4'b1010 || bit_cnt !== 2'd0) begin
            errors++;
            $display("FAIL p2s_load Q=%b cnt=%0d want 1010 0", Q, bit_cnt);
        end
        mode = 3'b010; sin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (sout !== es[i]) begin
                errors++;
                $display("FAIL p2s_sout_%0d sout=%b want %b", i, sout, es[i]);
            end
            tick();
            checks++;
            if (Q !== eq[i] || frame_done !== (i == 3)) begin
                errors++;
                $display("FAIL p2s_q_%0d Q=%b fd=%b want %b %b", i, Q, frame_done, eq[i], i == 3);
            end
        end
    endtask

    task automatic test_rotate_asr();
        logic [3:0] eq [4];
        eq = '{4'b1101, 4'b1110, 4'b0111, 4'b1011};
        en = 1'b1; mode = 3'b101; D = 4'b1011; sin = 1'b0;
        tick();
        mode = 3'b011;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (Q !== eq[i] || frame_done !== (i == 3)) begin
                errors++;
                $display("FAIL ror_%0d Q=%b fd=%b want %b %b", i, Q, frame_done, eq[i], i == 3);
            end
        end
        mode = 3'b101; D = 4'b1000;
        tick();
        mode = 3'b110;
        tick();
        checks++;
        if (Q !== 4'b1100) begin
            errors++;
            $display("FAIL asr_0 Q=%b want 1100", Q);
        end
        tick();
        checks++;
        if (Q !== 4'b1110 || bit_cnt !== 2'd2) begin
            errors++;
            $display("FAIL asr_1 Q=%b cnt=%0d want 1110 2", Q, bit_cnt);
        end
    endtask

    task automatic test_enable_abort();
        en = 1'b1; mode = 3'b101; D = 4'b1100; sin = 1'b0;
        tick();
        mode = 3'b001;
        tick();
        tick();
        checks++;
        if (Q !== 4'b0011 || bit_cnt !== 2'd2) begin
            errors++;
            $display("FAIL en_pre Q=%b cnt=%0d want 0011 2", Q, bit_cnt);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (Q !== 4'b0011 || bit_cnt !== 2'd2 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL en_hold_%0d Q=%b cnt=%0d fd=%b want 0011 2 0", i, Q, bit_cnt, frame_done);
            end
        end
        mode = 3'b100;
        #1;
        checks++;
        if (sout !== 1'b0) begin
            errors++;
            $display("FAIL en_sout_msb sout=%b want 0", sout);
        end
        mode = 3'b011;
        #1;
        checks++;
        if (sout !== 1'b1) begin
            errors++;
            $display("FAIL en_sout_lsb sout=%b want 1", sout);
        end
        en = 1'b1; mode = 3'b111;
        tick();
        checks++;
        if (Q !== 4'b0000 || bit_cnt !== 2'd0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_clr Q=%b cnt=%0d fd=%b want 0000 0 0", Q, bit_cnt, frame_done);
        end
        mode = 3'b001;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (frame_done !== (i == 3)) begin
                errors++;
                $display("FAIL abort_frame_%0d fd=%b want %b", i, frame_done, i == 3);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        en = 1'b1; mode = 3'b111;
        tick();
        mode = 3'b010; sin = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bit_cnt !== 2'd3 || Q !== 4'b0111) begin
            errors++;
            $display("FAIL mid_pre cnt=%0d Q=%b want 3 0111", bit_cnt, Q);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (Q !== 4'b0000 || bit_cnt !== 2'd0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset Q=%b cnt=%0d fd=%b want 0000 0 0", Q, bit_cnt, frame_done);
        end
        @(posedge clk);
        #1;
        checks++;
        if (frame_done !== 1'b0 || bit_cnt !== 2'd0) begin
            errors++;
            $display("FAIL mid_held fd=%b cnt=%0d want 0 0", frame_done, bit_cnt);
        end
        #2 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (frame_done !== (i == 3)) begin
                errors++;
                $display("FAIL mid_frame_%0d fd=%b cnt=%0d want %b", i, frame_done, bit_cnt, i == 3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_s2p();
        test_p2s();
        test_rotate_asr();
        test_enable_abort();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register, the successor to the fixed 4-bit serial/parallel shift register. It supports configurable width, an 8-way operation mode (shift, rotate, arithmetic shift, load, clear, hold), and a clock enable. A frame counter pulses `frame_done` after every WIDTH shift operations, so the block can run directly as a serial-to-parallel or parallel-to-serial converter in FSM datapaths.

## Interface
- `WIDTH`, default 4: register width in bits; legal range WIDTH ≥ 2.
- `RESET_VALUE`, default 0: value of Q after reset; WIDTH bits.
- `CNT_W`, default $clog2(WIDTH): width of bit_cnt; derived, not overridden.

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `en`  in  1: clock enable. When 0, Q and bit_cnt hold.
- `mode`  in  3: operation select, see Operation.
- `sin`  in  1: serial input.
- `D`  in  WIDTH: parallel load data.
- `Q`  out  WIDTH: register contents.
- `sout`  out  1: serial output, the bit that will leave on the next shift.
- `bit_cnt`  out  CNT_W: shift operations completed in the current frame.
- `frame_done`  out  1: one-cycle pulse when a frame of WIDTH shifts completes.

## Operation
- Reset (reset=0) takes effect immediately and does not wait for clk:
  - Q=RESET_VALUE, bit_cnt=0, frame_done=0.
- The following apply on each rising edge with en=1:
  - 000 hold: Q unchanged, bit_cnt unchanged.
  - 001 shift right: Q ← {sin, Q[WIDTH-1:1]}.
  - 010 shift left: Q ← {Q[WIDTH-2:0], sin}.
  - 011 rotate right: Q ← {Q[0], Q[WIDTH-1:1]}. sin is ignored.
  - 100 rotate left: Q ← {Q[WIDTH-2:0], Q[WIDTH-1]}. sin is ignored.
  - 101 parallel load: Q ← D, bit_cnt ← 0.
  - 110 arithmetic shift right: Q ← {Q[WIDTH-1], Q[WIDTH-1:1]}. sin is ignored.
  - 111 clear: Q ← 0, bit_cnt ← 0.
- Shift-class modes are 001, 010, 011, 100 and 110.
  - Each one increments bit_cnt, modulo WIDTH.
  - When bit_cnt = WIDTH-1, the increment wraps bit_cnt to 0 and sets frame_done=1 for the following cycle.
- frame_done is 0 in every cycle not immediately after a wrap, including when en=0.
- sout is combinational from Q and mode:
  - Q[WIDTH-1] for modes 010 and 100.
  - Q[0] for all other modes.
- en=0: all state holds and mode is ignored. The sout mapping still follows the current mode.
- For non-power-of-two WIDTH, bit_cnt never exceeds WIDTH-1.

## Timing
- All state is registered. Q, bit_cnt and frame_done update one clk edge after the inputs are sampled; latency is 1 cycle.
- sout has zero latency from Q and mode, with no register.
- A serial frame takes exactly WIDTH enabled shift edges. frame_done is high during the cycle after the WIDTH-th edge.
- Load or clear mid-frame restarts the frame (bit_cnt=0). No frame_done pulse is produced for the partial frame.
- A mode change between shift classes mid-frame does not reset bit_cnt. The count continues.
- Reset asserted mid-frame:
  - Clears state asynchronously and aborts any pending frame_done.
  - After release, the first edge with reset=1 is a normal operation edge.
- Reset release is synchronised externally. The block does not self-synchronise.

## Test plan
All scenarios use WIDTH=4 and RESET_VALUE=0.
1. Reset: drive reset=0 mid-cycle, between edges, after Q=4'b1111 and bit_cnt=2 → Q=0000, bit_cnt=0 and frame_done=0 before the next edge.
2. Serial-to-parallel: mode=001, en=1, sin=1,0,0,1 on four edges from Q=0 → Q=1000, 0100, 0010, 1001; bit_cnt=1,2,3,0; frame_done=1 only in the cycle after edge 4.
3. Parallel-to-serial: mode=101 with D=1010, then mode=010 with sin=0 for 4 edges:
   - Q after the load edge = 1010, bit_cnt=0.
   - sout before each shift edge = 1, 0, 1, 0.
   - Final Q=0000; frame_done pulses once.
4. Rotate and arithmetic shift:
   - Load 1011, then mode=011 for 4 edges → Q=1101, 1110, 0111, 1011, with frame_done after edge 4.
   - Load 1000, then mode=110 for 2 edges → Q=1100, 1110.
5. Enable and abort:
   - mode=001 for 2 edges, then en=0 for 3 edges → Q and bit_cnt=2 held; frame_done stays 0.
   - Then mode=111 → Q=0000, bit_cnt=0.
   - A subsequent frame_done requires 4 more shift edges.
6. Reset mid-frame: after 3 shift edges (bit_cnt=3), pulse reset low → no frame_done; 4 further shift edges are needed before frame_done=1.
